ysyx_23060072_wb_stage: RTL and testbench

- Final pipeline stage; sole writer of the regfile write port (wb_flag, wb_reg_addr, wb_reg_data) consumed by the decode stage.
- Formats load data (byte/half/word lane select, sign/zero extension).
- Arbitrates the single write port between in-order pipeline results and late multdiv completions, using a one-entry pending buffer.
- Exposes the current write to the forwarding unit.

---
 rtl/ysyx_23060072_wb_stage.sv | 158 +++++++++++++++
 tb/tb_ysyx_23060072_wb_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_wb_stage.sv
// ysyx_23060072_wb_stage -- final pipeline stage and sole writer of the regfile write port.
//
// Purpose:
//   - Formats load data: byte/half/word lane select with sign or zero extension.
//   - Shares the single regfile write port between in-order pipeline results and late
//     multdiv completions. A one-entry pending buffer holds a multdiv result that arrives
//     while the pipeline is writing.
//   - Registers the write (1-cycle latency) and exposes it to decode/forwarding.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_*_i           MEM-stage slot: valid, rd write flag/address, result (or load
//                     address), load flag, lsu type (0=B,1=H,2=W), signed flag, raw load word
//   md_valid_i/md_waddr_i/md_result_i, md_ready_o
//                     multdiv completion handshake; md_ready_o is combinational
//   hold_flag_i       stall: no pipeline capture (pending/md writes continue)
//   clean_flag_i      flush: drop the pipeline slot (pending survives)
//   wb_flag_o/wb_reg_addr_o/wb_reg_data_o
//                     registered regfile write port
//   retire_o          one pulse per accepted pipeline instruction
//   minstret_o        64-bit retire counter, only with YSYX_23060072_WB_MINSTRET_EN defined
//
// Optional feature macro: YSYX_23060072_WB_MINSTRET_EN
module ysyx_23060072_wb_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    input  logic              mem_wb_flag_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic              mem_load_flag_i,
    input  logic [1:0]        mem_lsu_type_i,
    input  logic              mem_lsu_signed_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              md_valid_i,
    input  logic [REG_AW-1:0] md_waddr_i,
    input  logic [XLEN-1:0]   md_result_i,
    output logic              md_ready_o,
    input  logic              hold_flag_i,
    input  logic              clean_flag_i,
    output logic              wb_flag_o,
    output logic [REG_AW-1:0] wb_reg_addr_o,
    output logic [XLEN-1:0]   wb_reg_data_o,
`ifdef YSYX_23060072_WB_MINSTRET_EN
    output logic [63:0]       minstret_o,
`endif
    output logic              retire_o
);

    logic              pa;
    logic              pw;
    logic              md_acc;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   pipe_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    logic              pend_valid_q, pend_valid_d;
    logic [REG_AW-1:0] pend_addr_q,  pend_addr_d;
    logic [XLEN-1:0]   pend_data_q,  pend_data_d;

    logic              wb_flag_d;
    logic [REG_AW-1:0] wb_addr_d;
    logic [XLEN-1:0]   wb_data_d;

    assign pa         = mem_valid_i & ~hold_flag_i & ~clean_flag_i;
    assign pw         = pa & mem_wb_flag_i & (mem_waddr_i != '0);
    assign md_ready_o = md_valid_i & ~pend_valid_q;
    assign md_acc     = md_ready_o;

    // Load lane select and extension; rdata is the aligned word containing the access.
    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = 16'h0000;
        load_data = mem_rdata_i;
        unique case (mem_result_i[1:0])
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = mem_result_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (mem_lsu_type_i)
            2'd0: load_data = {{(XLEN-8){mem_lsu_signed_i & ld_byte[7]}}, ld_byte};
            2'd1: load_data = {{(XLEN-16){mem_lsu_signed_i & ld_half[15]}}, ld_half};
            default: load_data = mem_rdata_i;
        endcase
    end

    assign pipe_data = mem_load_flag_i ? load_data : mem_result_i;

    // Port arbitration: pipeline > pending > direct multdiv.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        wb_flag_d    = 1'b0;
        wb_addr_d    = wb_reg_addr_o;
        wb_data_d    = wb_reg_data_o;
        if (pw) begin
            wb_flag_d = 1'b1;
            wb_addr_d = mem_waddr_i;
            wb_data_d = pipe_data;
            // A younger pipeline write to the same rd makes the older multdiv result stale.
            if (pend_valid_q && pend_addr_q == mem_waddr_i) begin
                pend_valid_d = 1'b0;
            end
            if (md_acc && md_waddr_i != '0 && md_waddr_i != mem_waddr_i) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = md_waddr_i;
                pend_data_d  = md_result_i;
            end
        end else if (pend_valid_q) begin
            wb_flag_d    = 1'b1;
            wb_addr_d    = pend_addr_q;
            wb_data_d    = pend_data_q;
            pend_valid_d = 1'b0;
        end else if (md_acc && md_waddr_i != '0) begin
            wb_flag_d = 1'b1;
            wb_addr_d = md_waddr_i;
            wb_data_d = md_result_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            wb_flag_o     <= 1'b0;
            wb_reg_addr_o <= '0;
            wb_reg_data_o <= '0;
            retire_o      <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            wb_flag_o     <= wb_flag_d;
            wb_reg_addr_o <= wb_addr_d;
            wb_reg_data_o <= wb_data_d;
            retire_o      <= pa;
        end
    end

`ifdef YSYX_23060072_WB_MINSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minstret_o <= 64'd0;
        end else if (retire_o) begin
            minstret_o <= minstret_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060072_wb_stage.sv
module tb_ysyx_23060072_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i, mem_wb_flag_i, mem_load_flag_i, mem_lsu_signed_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_result_i, mem_rdata_i;
    logic [1:0]  mem_lsu_type_i;
    logic        md_valid_i, md_ready_o;
    logic [4:0]  md_waddr_i;
    logic [31:0] md_result_i;
    logic        hold_flag_i, clean_flag_i;
    logic        wb_flag_o, retire_o;
    logic [4:0]  wb_reg_addr_o;
    logic [31:0] wb_reg_data_o;
`ifdef YSYX_23060072_WB_MINSTRET_EN
    logic [63:0] minstret_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    ysyx_23060072_wb_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_valid_i      (mem_valid_i),
        .mem_wb_flag_i    (mem_wb_flag_i),
        .mem_waddr_i      (mem_waddr_i),
        .mem_result_i     (mem_result_i),
        .mem_load_flag_i  (mem_load_flag_i),
        .mem_lsu_type_i   (mem_lsu_type_i),
        .mem_lsu_signed_i (mem_lsu_signed_i),
        .mem_rdata_i      (mem_rdata_i),
        .md_valid_i       (md_valid_i),
        .md_waddr_i       (md_waddr_i),
        .md_result_i      (md_result_i),
        .md_ready_o       (md_ready_o),
        .hold_flag_i      (hold_flag_i),
        .clean_flag_i     (clean_flag_i),
        .wb_flag_o        (wb_flag_o),
        .wb_reg_addr_o    (wb_reg_addr_o),
        .wb_reg_data_o    (wb_reg_data_o),
`ifdef YSYX_23060072_WB_MINSTRET_EN
        .minstret_o       (minstret_o),
`endif
        .retire_o         (retire_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_valid_i = 0; mem_wb_flag_i = 0; mem_waddr_i = 0; mem_result_i = 0;
        mem_load_flag_i = 0; mem_lsu_type_i = 0; mem_lsu_signed_i = 0; mem_rdata_i = 0;
        md_valid_i = 0; md_waddr_i = 0; md_result_i = 0;
        hold_flag_i = 0; clean_flag_i = 0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        mem_valid_i = 1; mem_wb_flag_i = 1; mem_waddr_i = a; mem_result_i = d;
        mem_load_flag_i = 0;
    endtask

    task automatic load(input logic [1:0] ty, input logic sg, input logic [31:0] addr,
                        input logic [31:0] rd);
        mem_valid_i = 1; mem_wb_flag_i = 1; mem_waddr_i = 5; mem_result_i = addr;
        mem_load_flag_i = 1; mem_lsu_type_i = ty; mem_lsu_signed_i = sg; mem_rdata_i = rd;
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d);
        md_valid_i = 1; md_waddr_i = a; md_result_i = d;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic f, input logic [4:0] a,
                      input logic [31:0] d, input logic r);
        chk({tag, "_flag"}, {63'd0, wb_flag_o}, {63'd0, f});
        if (f) begin
            chk({tag, "_addr"}, {59'd0, wb_reg_addr_o}, {59'd0, a});
            chk({tag, "_data"}, {32'd0, wb_reg_data_o}, {32'd0, d});
        end
        chk({tag, "_retire"}, {63'd0, retire_o}, {63'd0, r});
    endtask

    initial begin
        idle();
        rst_n = 0;
        #1;
        chk("rst_flag", {63'd0, wb_flag_o}, 64'd0);
        chk("rst_addr", {59'd0, wb_reg_addr_o}, 64'd0);
        chk("rst_data", {32'd0, wb_reg_data_o}, 64'd0);
        chk("rst_retire", {63'd0, retire_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Load formatting
        load(2'd0, 1, 32'h0000_1003, 32'h8000_7F80); tick();
        wr("lb_s", 1, 5, 32'hFFFF_FF80, 1);
        load(2'd0, 0, 32'h0000_1003, 32'h8000_7F80); tick();
        wr("lbu", 1, 5, 32'h0000_0080, 1);
        load(2'd0, 1, 32'h0000_1001, 32'h8000_7F80); tick();
        wr("lb_lane1", 1, 5, 32'h0000_007F, 1);
        load(2'd1, 1, 32'h0000_1002, 32'h8000_7F80); tick();
        wr("lh_hi", 1, 5, 32'hFFFF_8000, 1);
        load(2'd1, 0, 32'h0000_1000, 32'h8000_7F80); tick();
        wr("lhu_lo", 1, 5, 32'h0000_7F80, 1);
        load(2'd2, 1, 32'h0000_1000, 32'h8000_7F80); tick();
        wr("lw", 1, 5, 32'h8000_7F80, 1);
        idle(); pipe(5'd2, 32'h1234_5678); tick();
        wr("alu", 1, 2, 32'h1234_5678, 1);

        // Collision: pipeline first, multdiv buffered
        idle(); pipe(5'd3, 32'h11); md(5'd7, 32'h22); #1;
        chk("col_ready", {63'd0, md_ready_o}, 64'd1);
        tick();
        wr("col_x3", 1, 3, 32'h11, 1);
        idle(); md(5'd8, 32'h44); #1;
        chk("col_busy", {63'd0, md_ready_o}, 64'd0);
        md_valid_i = 0;
        tick();
        wr("col_x7", 1, 7, 32'h22, 0);
        idle(); tick();
        wr("col_idle", 0, 0, 0, 0);
        chk("hold_addr", {59'd0, wb_reg_addr_o}, 64'd7);

        // Stale drop of buffered result
        pipe(5'd4, 32'h55); md(5'd7, 32'h22); tick();
        wr("stale_x4", 1, 4, 32'h55, 1);
        idle(); pipe(5'd7, 32'h33); tick();
        wr("stale_x7", 1, 7, 32'h33, 1);
        idle(); tick();
        wr("stale_none", 0, 0, 0, 0);

        // Same-cycle multdiv to same rd is accepted and dropped
        pipe(5'd6, 32'h66); md(5'd6, 32'h77); #1;
        chk("same_ready", {63'd0, md_ready_o}, 64'd1);
        tick();
        wr("same_x6", 1, 6, 32'h66, 1);
        idle(); tick();
        wr("same_none", 0, 0, 0, 0);

        // Multdiv to x0 discarded
        md(5'd0, 32'h99); #1;
        chk("md_x0_ready", {63'd0, md_ready_o}, 64'd1);
        tick();
        wr("md_x0", 0, 0, 0, 0);

        // x0 suppression
        idle(); pipe(5'd0, 32'hDEAD); tick();
        wr("x0", 0, 0, 0, 1);

        // Flush keeps pending
        idle(); pipe(5'd10, 32'hA); md(5'd9, 32'h99); tick();
        wr("fl_x10", 1, 10, 32'hA, 1);
        idle(); pipe(5'd11, 32'hBB); clean_flag_i = 1; tick();
        wr("fl_x9", 1, 9, 32'h99, 0);
        idle(); tick();
        wr("fl_none", 0, 0, 0, 0);

        // Hold for 3 cycles; multdiv still writes directly
        pipe(5'd12, 32'hC); hold_flag_i = 1; md(5'd13, 32'hD); #1;
        chk("hold_ready", {63'd0, md_ready_o}, 64'd1);
        tick();
        wr("hold1", 1, 13, 32'hD, 0);
        md_valid_i = 0; tick();
        wr("hold2", 0, 0, 0, 0);
        tick();
        wr("hold3", 0, 0, 0, 0);
        hold_flag_i = 0; tick();
        wr("hold_rel", 1, 12, 32'hC, 1);

        // Async reset mid-cycle with pending full
        idle(); pipe(5'd14, 32'hE); md(5'd15, 32'hF); tick();
        wr("ar_x14", 1, 14, 32'hE, 1);
        idle();
        #2;
        rst_n = 0;
        #1;
        chk("ar_flag", {63'd0, wb_flag_o}, 64'd0);
        chk("ar_addr", {59'd0, wb_reg_addr_o}, 64'd0);
        chk("ar_data", {32'd0, wb_reg_data_o}, 64'd0);
        chk("ar_retire", {63'd0, retire_o}, 64'd0);
`ifdef YSYX_23060072_WB_MINSTRET_EN
        chk("ar_minstret", minstret_o, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1;
        tick();
        wr("ar_post1", 0, 0, 0, 0);
        tick();
        wr("ar_post2", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
